// File: rtl/sign_ext_pipe.sv
// sign_ext_pipe: RISC-V immediate extractor/sign-extender with PC-relative target, behind a 2-entry skid-buffered valid/ready stage.
// Ports: clk, rst (async, active-high), flush (sync discard of all held entries);
//        in_valid/in_ready with inst, type_SE, pc on the decode side;
//        out_valid/out_ready with inmExt, target (pc + inmExt) and misalign (B/J target[1]) on the execute side.
module sign_ext_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [2:0]      type_SE,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] inmExt,
    output logic [XLEN-1:0] target,
    output logic            misalign
);
    localparam int W = 2 * XLEN + 1;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state, state_n;
    logic [XLEN-1:0] imm, tgt;
    logic mis, accept, ld_in, ld_skid, ld_fwd;
    logic [W-1:0] main_q, skid_q;
    // signed size casts replicate inst[31] up to XLEN
    always_comb begin
        imm = '0;
        case (type_SE)
            3'b000: imm = XLEN'($signed(inst[31:20]));
            3'b001: imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            3'b010: imm = XLEN'($signed({inst[31:12], 12'b0}));
            3'b011: imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            3'b100: imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            3'b101: imm = XLEN == 64 ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
            3'b110: imm = XLEN'(inst[19:15]);
            default: imm = '0;
        endcase
    end
    assign tgt       = pc + imm;
    assign mis       = (type_SE == 3'b011 || type_SE == 3'b100) && tgt[1];
    assign in_ready  = state != FULL;
    assign out_valid = state != EMPTY;
    assign accept    = in_valid && in_ready;
    assign {misalign, target, inmExt} = main_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= EMPTY;
        else     state <= state_n;
    // load enables are suppressed on flush so nothing discarded is ever written
    always_comb begin
        state_n = state;
        ld_in   = 1'b0;
        ld_skid = 1'b0;
        ld_fwd  = 1'b0;
        case (state)
            EMPTY: begin
                ld_in   = accept;
                state_n = accept ? ONE : EMPTY;
            end
            ONE: begin
                ld_in   = accept && out_ready;
                ld_skid = accept && !out_ready;
                state_n = ld_skid ? FULL : (!accept && out_ready) ? EMPTY : ONE;
            end
            FULL: begin
                ld_fwd  = out_ready;
                state_n = out_ready ? ONE : FULL;
            end
            default: state_n = EMPTY;
        endcase
        if (flush) begin
            state_n = EMPTY;
            ld_in   = 1'b0;
            ld_skid = 1'b0;
            ld_fwd  = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_in)       main_q <= {mis, tgt, imm};
            else if (ld_fwd) main_q <= skid_q;
            if (ld_skid)     skid_q <= {mis, tgt, imm};
        end
endmodule

// File: tb/tb_sign_ext_pipe.sv
// tb_sign_ext_pipe: scoreboard bench for sign_ext_pipe at XLEN=32 and XLEN=64 sharing one stimulus stream.
module tb_sign_ext_pipe;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] inst = '0;
    logic [2:0] type_SE = '0;
    logic [63:0] pc64 = '0;
    logic [31:0] pc32;
    logic in_ready32, out_valid32, mis32, in_ready64, out_valid64, mis64;
    logic [31:0] imm32, tgt32;
    logic [63:0] imm64, tgt64;
    int n_tests = 0, n_fail = 0, occ;

    typedef struct packed {logic [63:0] imm; logic [63:0] tgt; logic mis;} exp_t;
    exp_t q32[$], q64[$];

    assign pc32 = pc64[31:0];
    always #5 clk = ~clk;

    sign_ext_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .inst(inst), .type_SE(type_SE), .pc(pc32), .out_valid(out_valid32), .out_ready(out_ready),
        .inmExt(imm32), .target(tgt32), .misalign(mis32));
    sign_ext_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .inst(inst), .type_SE(type_SE), .pc(pc64), .out_valid(out_valid64), .out_ready(out_ready),
        .inmExt(imm64), .target(tgt64), .misalign(mis64));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint sx(input logic [63:0] x, input int n);
        longint y = longint'(x << (64 - n));
        return y >>> (64 - n);
    endfunction

    function automatic exp_t model(input logic [31:0] i, input logic [2:0] t, input logic [63:0] p, input int xl);
        longint v;
        logic [63:0] mask = xl == 32 ? 64'h0000_0000_FFFF_FFFF : '1;
        exp_t e;
        case (t)
            3'd0: v = sx(64'(i[31:20]), 12);
            3'd1: v = sx(64'({i[31:25], i[11:7]}), 12);
            3'd2: v = sx(64'({i[31:12], 12'b0}), 32);
            3'd3: v = sx(64'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
            3'd4: v = sx(64'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
            3'd5: v = xl == 64 ? longint'(i[25:20]) : longint'(i[24:20]);
            3'd6: v = longint'(i[19:15]);
            default: v = 0;
        endcase
        e.imm = 64'(v) & mask;
        e.tgt = (p + e.imm) & mask;
        e.mis = (t == 3'd3 || t == 3'd4) && e.tgt[1];
        return e;
    endfunction

    // Scoreboard: occupancy of the queue is the expected number of held entries.
    always @(negedge clk) begin
        if (rst) begin
            q32.delete();
            q64.delete();
        end else begin
            occ = q32.size();
            check("out_valid32", 64'(out_valid32), 64'(occ > 0));
            check("in_ready32", 64'(in_ready32), 64'(occ < 2));
            check("out_valid64", 64'(out_valid64), 64'(occ > 0));
            check("in_ready64", 64'(in_ready64), 64'(occ < 2));
            if (occ > 0 && out_valid32) begin
                check("sb_imm32", 64'(imm32), q32[0].imm);
                check("sb_tgt32", 64'(tgt32), q32[0].tgt);
                check("sb_mis32", 64'(mis32), 64'(q32[0].mis));
                check("sb_imm64", imm64, q64[0].imm);
                check("sb_tgt64", tgt64, q64[0].tgt);
                check("sb_mis64", 64'(mis64), 64'(q64[0].mis));
            end
            if (occ > 0 && out_ready) begin
                void'(q32.pop_front());
                void'(q64.pop_front());
            end
            if (flush) begin
                q32.delete();
                q64.delete();
            end else if (in_valid && occ < 2) begin
                q32.push_back(model(inst, type_SE, pc64, 32));
                q64.push_back(model(inst, type_SE, pc64, 64));
            end
        end
    end

    task automatic directed(input string nm, input logic [31:0] i, input logic [2:0] t, input logic [63:0] p,
                            input logic [31:0] ei, input logic [31:0] et, input logic em, input logic [63:0] ei64);
        out_ready = 1'b1;
        in_valid = 1'b1;
        inst = i;
        type_SE = t;
        pc64 = p;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({nm, "_imm"}, 64'(imm32), 64'(ei));
        check({nm, "_tgt"}, 64'(tgt32), 64'(et));
        check({nm, "_mis"}, 64'(mis32), 64'(em));
        check({nm, "_imm64"}, imm64, ei64);
    endtask

    task automatic offer(input logic [31:0] i);
        in_valid = 1'b1;
        inst = i;
        type_SE = 3'd0;
        pc64 = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        check("rst_out_valid", 64'(out_valid32), 64'(0));
        check("rst_in_ready", 64'(in_ready32), 64'(1));
        check("rst_imm", 64'(imm32), 64'(0));
        check("rst_tgt", 64'(tgt32), 64'(0));
        check("rst_mis", 64'(mis32), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        directed("i_type", 32'hFFF00093, 3'd0, 64'h100, 32'hFFFFFFFF, 32'h000000FF, 1'b0, 64'hFFFFFFFF_FFFFFFFF);
        directed("b_wrap", 32'hFE000EE3, 3'd3, 64'h0, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFF_FFFFFFFC);
        directed("u_pos", 32'h123450B7, 3'd2, 64'h0, 32'h12345000, 32'h12345000, 1'b0, 64'h00000000_12345000);
        directed("u_neg", 32'h800000B7, 3'd2, 64'h0, 32'h80000000, 32'h80000000, 1'b0, 64'hFFFFFFFF_80000000);
        directed("j_mis", 32'h0020006F, 3'd4, 64'h100, 32'h2, 32'h102, 1'b1, 64'h2);
        directed("shamt", 32'h0020006F, 3'd5, 64'h100, 32'h2, 32'h102, 1'b0, 64'h2);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        offer(32'h00100093);
        check("bp_ready_one", 64'(in_ready32), 64'(1));
        offer(32'h00200093);
        check("bp_full", 64'(in_ready32), 64'(0));
        offer(32'h00300093);
        check("bp_hold_c", 64'(in_ready32), 64'(0));
        check("bp_out_a", 64'(imm32), 64'(1));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ready_back", 64'(in_ready32), 64'(1));
        check("bp_out_b", 64'(imm32), 64'(2));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_out_c", 64'(imm32), 64'(3));
        @(posedge clk);
        #1;
        check("bp_drained", 64'(out_valid32), 64'(0));
        out_ready = 1'b0;
        offer(32'h00400093);
        offer(32'h00500093);
        flush = 1'b1;
        offer(32'h00600093);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 64'(out_valid32), 64'(0));
        check("flush_ready", 64'(in_ready32), 64'(1));
        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("flush_no_emit", 64'(out_valid32), 64'(0));
        end
        out_ready = 1'b0;
        offer(32'h00700093);
        offer(32'h80800093);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid32), 64'(0));
        check("arst_ready", 64'(in_ready32), 64'(1));
        check("arst_imm", 64'(imm32), 64'(0));
        check("arst_tgt", 64'(tgt32), 64'(0));
        check("arst_imm64", imm64, 64'(0));
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("arst_ignore", 64'(out_valid32), 64'(0));
        in_valid = 1'b0;
        rst = 1'b0;
        repeat (800) begin
            in_valid = $urandom_range(0, 9) < 7;
            out_ready = $urandom_range(0, 9) < 6;
            flush = $urandom_range(0, 49) == 0;
            inst = $urandom;
            type_SE = 3'($urandom_range(0, 7));
            pc64 = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
